router_ctrl_fsm: RTL and testbench
==================================

# router_ctrl_fsm

Packet-sequencing controller for the 1x3 router. Watches the input packet stream and the three output FIFOs, and steps the router datapath through header decode, first-byte load, payload load, full-FIFO stall and parity check. It drives the register block's load strobes and the `write_enb_reg` consumed by the synchroniser. It also asserts `busy` to hold off the source.

## Interface
- No parameters; the state encoding is internal (3-bit, binary).
- `clock` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `pkt_valid` in 1: source is presenting packet bytes; deasserts after the last payload byte.
- `data_in` in 2: header address bits `[1:0]`, valid while in DECODE.
- `fifo_full` in 1: full flag of the currently addressed FIFO, muxed by the synchroniser.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-port FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-port read-timeout abort pulses.
- `parity_done` in 1: register block has captured the parity byte.
- `low_packet_valid` in 1: `pkt_valid` fell while the FSM was stalled on full.
- `detect_add` out 1: latch header address (DECODE).
- `lfd_state` out 1: load-first-data (header) strobe.
- `ld_state` out 1: payload load strobe.
- `laf_state` out 1: load-after-full strobe.
- `full_state` out 1: FSM is stalled on a full FIFO.
- `write_enb_reg` out 1: FIFO write permitted.
- `rst_int_reg` out 1: clear internal parity registers (CHECK state).
- `busy` out 1: source must hold the current byte.

## Operation
- States: DECODE, LFD, LOAD_DATA, FULL, LAF, LOAD_PARITY, CHECK, WAIT_EMPTY. Single state register.
- Internal `addr_q[1:0]` is loaded from `data_in` on the DECODE->(LFD|WAIT_EMPTY) transition only.
- `empty_sel` = `fifo_empty_<addr_q>`; `soft_sel` = `soft_reset_<addr_q>`. When `addr_q`=3, both are 0.
- DECODE:
  - `pkt_valid` & `data_in`!=3 & `fifo_empty_<data_in>` -> LFD.
  - `pkt_valid` & `data_in`!=3 & !`fifo_empty_<data_in>` -> WAIT_EMPTY.
  - `data_in`==3 or !`pkt_valid` -> stay. Invalid address: the packet is ignored.
- WAIT_EMPTY: `empty_sel` -> LFD; else stay.
- LFD: -> LOAD_DATA, unconditionally.
- LOAD_DATA:
  - `fifo_full` -> FULL (full takes priority).
  - Else !`pkt_valid` -> LOAD_PARITY.
  - Else stay.
- FULL: !`fifo_full` -> LAF; else stay.
- LAF:
  - `parity_done` -> DECODE.
  - Else `low_packet_valid` -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY: -> CHECK.
- CHECK: `fifo_full` -> FULL; else -> DECODE.
- Abort: `soft_sel`=1 in any state other than DECODE forces next state DECODE. This overrides every transition above.
- Outputs are Moore, decoded from the state register:
  - `detect_add` = DECODE.
  - `lfd_state` = LFD.
  - `ld_state` = LOAD_DATA.
  - `laf_state` = LAF.
  - `full_state` = FULL.
  - `rst_int_reg` = CHECK.
  - `write_enb_reg` = LOAD_DATA | LAF | LOAD_PARITY.
  - `busy` = LFD | FULL | LAF | LOAD_PARITY | CHECK | WAIT_EMPTY.
- Unused encodings return to DECODE on the next edge.

## Timing
- Reset: `resetn`=0 at a rising edge -> state DECODE, `addr_q`=0.
  - Outputs then: `detect_add`=1, all other outputs 0.
  - Reset mid-packet discards the packet, with no partial strobes after the edge.
- Every state change takes effect at the edge following the qualifying inputs; outputs change in the same cycle as the state.
- Header byte:
  - Header sampled in DECODE (cycle 0).
  - `lfd_state` high in cycle 1.
  - `ld_state` high from cycle 2.
- Payload of N bytes: `ld_state` high for N cycles if never full.
  - `pkt_valid` low in LOAD_DATA -> LOAD_PARITY next cycle.
  - Then CHECK for 1 cycle.
  - Then DECODE.
  - Minimum packet turnaround: 1 + 1 + N + 1 + 1 cycles.
- `busy` is high during LFD, so the source holds the first payload byte one cycle after the header.
- `fifo_full` and `pkt_valid` fall in the same LOAD_DATA cycle -> FULL (full wins). The parity path is resumed via LAF/`low_packet_valid`.
- `soft_sel` and `fifo_full` both high in FULL -> DECODE.
- In DECODE, `soft_reset_x` is ignored.

## Test plan
- Reset: hold `resetn`=0 two cycles with random inputs -> `detect_add`=1, all others 0, state DECODE.
- Normal packet: address 1, `fifo_empty_1`=1, 4 payload bytes, then `pkt_valid`=0 -> states DECODE, LFD, LOAD_DATAx4, LOAD_PARITY, CHECK, DECODE. `write_enb_reg` high for 5 cycles.
- Busy port: address 2, `fifo_empty_2`=0 for 6 cycles then 1 -> WAIT_EMPTY for 6 cycles with `busy`=1, then LFD.
- Full stall: `fifo_full`=1 on the 2nd payload cycle for 3 cycles -> FULL x3, then LAF. With `low_packet_valid`=0 -> LOAD_DATA; with `low_packet_valid`=1 -> LOAD_PARITY.
- Abort: address 0, stall in FULL, pulse `soft_reset_0` -> DECODE next edge. A pulse on `soft_reset_1` in the same scenario has no effect.
- Invalid address: `data_in`=3 with `pkt_valid`=1 for 5 cycles -> remains DECODE, `busy`=0, no strobes.

Source files
------------

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm
//   Packet-sequencing controller for the 1x3 router. Steps the datapath
//   through header decode, first-byte load, payload load, full-FIFO stall
//   and parity check, and holds off the source with busy.
//
// Ports
//   clock                       rising-edge clock
//   resetn                      synchronous active-low reset
//   pkt_valid                   source is presenting packet bytes
//   data_in[1:0]                header address, valid in DECODE
//   fifo_full                   full flag of the addressed FIFO
//   fifo_empty_0/1/2            per-port FIFO empty flags
//   soft_reset_0/1/2            per-port read-timeout abort pulses
//   parity_done                 parity byte captured by register block
//   low_packet_valid            pkt_valid fell while stalled on full
//   detect_add                  DECODE state (latch header address)
//   lfd_state                   load-first-data strobe
//   ld_state                    payload load strobe
//   laf_state                   load-after-full strobe
//   full_state                  stalled on a full FIFO
//   write_enb_reg               FIFO write permitted
//   rst_int_reg                 clear internal parity registers
//   busy                        source must hold the current byte
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE      = 3'd0,
    LFD         = 3'd1,
    LOAD_DATA   = 3'd2,
    FULL        = 3'd3,
    LAF         = 3'd4,
    LOAD_PARITY = 3'd5,
    CHECK       = 3'd6,
    WAIT_EMPTY  = 3'd7
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] addr_q;
  logic [1:0] addr_nxt;
  logic       empty_sel;
  logic       soft_sel;
  logic       empty_in;

  // Flags of the latched port; address 3 selects nothing.
  always_comb begin
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    case (addr_q)
      2'd0: begin empty_sel = fifo_empty_0; soft_sel = soft_reset_0; end
      2'd1: begin empty_sel = fifo_empty_1; soft_sel = soft_reset_1; end
      2'd2: begin empty_sel = fifo_empty_2; soft_sel = soft_reset_2; end
      default: begin empty_sel = 1'b0; soft_sel = 1'b0; end
    endcase
  end

  // Empty flag of the port named by the header currently on data_in.
  always_comb begin
    empty_in = 1'b0;
    case (data_in)
      2'd0:    empty_in = fifo_empty_0;
      2'd1:    empty_in = fifo_empty_1;
      2'd2:    empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    case (state)
      DECODE: begin
        if (pkt_valid && (data_in != 2'd3)) begin
          addr_nxt  = data_in;
          state_nxt = empty_in ? LFD : WAIT_EMPTY;
        end
      end
      WAIT_EMPTY:  state_nxt = empty_sel ? LFD : WAIT_EMPTY;
      LFD:         state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_nxt = FULL;
        else if (!pkt_valid) state_nxt = LOAD_PARITY;
        else                 state_nxt = LOAD_DATA;
      end
      FULL:        state_nxt = fifo_full ? FULL : LAF;
      LAF: begin
        if (parity_done)           state_nxt = DECODE;
        else if (low_packet_valid) state_nxt = LOAD_PARITY;
        else                       state_nxt = LOAD_DATA;
      end
      LOAD_PARITY: state_nxt = CHECK;
      CHECK:       state_nxt = fifo_full ? FULL : DECODE;
      default:     state_nxt = DECODE;
    endcase
    // Abort of the addressed port wins over every transition outside DECODE.
    if ((state != DECODE) && soft_sel)
      state_nxt = DECODE;
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so they change in the same cycle as the state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= DECODE;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr_q        <= addr_nxt;
      detect_add    <= (state_nxt == DECODE);
      lfd_state     <= (state_nxt == LFD);
      ld_state      <= (state_nxt == LOAD_DATA);
      laf_state     <= (state_nxt == LAF);
      full_state    <= (state_nxt == FULL);
      rst_int_reg   <= (state_nxt == CHECK);
      write_enb_reg <= (state_nxt == LOAD_DATA) || (state_nxt == LAF) ||
                       (state_nxt == LOAD_PARITY);
      busy          <= (state_nxt == LFD) || (state_nxt == FULL) ||
                       (state_nxt == LAF) || (state_nxt == LOAD_PARITY) ||
                       (state_nxt == CHECK) || (state_nxt == WAIT_EMPTY);
    end
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
module tb_router_ctrl_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  router_ctrl_fsm dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .write_enb_reg    (write_enb_reg),
    .rst_int_reg      (rst_int_reg),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Reference model: phase names of a packet's life, independent of the DUT.
  localparam int P_IDLE = 10, P_HDR = 11, P_PAY = 12, P_STALL = 13,
                 P_RESUME = 14, P_PAR = 15, P_CHK = 16, P_WAIT = 17;

  int         m_phase;
  int         m_port;
  int         checks = 0;
  int         errors = 0;
  string      tag = "reset";
  bit   [7:0] exp_q[$];
  string      tag_q[$];

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  function automatic bit [7:0] expect_of(input int ph);
    bit [7:0] e;
    e[7] = (ph == P_IDLE);
    e[6] = (ph == P_HDR);
    e[5] = (ph == P_PAY);
    e[4] = (ph == P_RESUME);
    e[3] = (ph == P_STALL);
    e[2] = (ph == P_PAY) || (ph == P_RESUME) || (ph == P_PAR);
    e[1] = (ph == P_CHK);
    e[0] = (ph != P_IDLE) && (ph != P_PAY);
    return e;
  endfunction

  task automatic model_edge();
    bit [2:0] empties;
    bit [2:0] aborts;
    int nx;
    empties = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    aborts  = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (!resetn) begin
      m_phase = P_IDLE;
      m_port  = 0;
    end else begin
      nx = m_phase;
      if (m_phase == P_IDLE) begin
        if (pkt_valid && data_in != 2'd3) begin
          m_port = int'(data_in);
          nx = empties[m_port] ? P_HDR : P_WAIT;
        end
      end else if (m_phase == P_WAIT)   nx = (m_port < 3 && empties[m_port]) ? P_HDR : P_WAIT;
      else if (m_phase == P_HDR)        nx = P_PAY;
      else if (m_phase == P_PAY)        nx = fifo_full ? P_STALL : (pkt_valid ? P_PAY : P_PAR);
      else if (m_phase == P_STALL)      nx = fifo_full ? P_STALL : P_RESUME;
      else if (m_phase == P_RESUME)     nx = parity_done ? P_IDLE : (low_packet_valid ? P_PAR : P_PAY);
      else if (m_phase == P_PAR)        nx = P_CHK;
      else if (m_phase == P_CHK)        nx = fifo_full ? P_STALL : P_IDLE;
      if (m_phase != P_IDLE && m_port < 3 && aborts[m_port]) nx = P_IDLE;
      m_phase = nx;
    end
  endtask

  // One clock: inputs already driven; the model follows the edge and the
  // expected outputs are queued for the monitor.
  task automatic tick();
    @(posedge clock);
    model_edge();
    exp_q.push_back(expect_of(m_phase));
    tag_q.push_back(tag);
    @(negedge clock);
    #1;
  endtask

  task automatic quiet();
    resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;
  endtask

  task automatic rand_inputs(input bit rst_allowed);
    resetn           = rst_allowed ? ($urandom_range(0, 49) != 0) : 1'b1;
    pkt_valid        = ($urandom_range(0, 3) != 0);
    data_in          = 2'($urandom_range(0, 3));
    fifo_full        = ($urandom_range(0, 4) == 0);
    fifo_empty_0     = ($urandom_range(0, 2) != 0);
    fifo_empty_1     = ($urandom_range(0, 2) != 0);
    fifo_empty_2     = ($urandom_range(0, 2) != 0);
    soft_reset_0     = ($urandom_range(0, 24) == 0);
    soft_reset_1     = ($urandom_range(0, 24) == 0);
    soft_reset_2     = ($urandom_range(0, 24) == 0);
    parity_done      = ($urandom_range(0, 3) == 0);
    low_packet_valid = ($urandom_range(0, 2) == 0);
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  always @(negedge clock) begin
    bit [7:0] act;
    bit [7:0] exp;
    string    t;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs[%s] t=%0t actual=%b required=%b", t, $time, act, exp);
      end
    end
  end

  initial begin
    m_phase = P_IDLE;
    m_port  = 0;

    // Reset with random inputs for two cycles
    tag = "reset";
    rand_inputs(1'b0);
    resetn = 1'b0;
    tick();
    rand_inputs(1'b0);
    resetn = 1'b0;
    tick();

    // Normal packet: port 1, 4 payload bytes
    tag = "normal";
    quiet();
    pkt_valid = 1'b1; data_in = 2'd1;
    tick();                                // DECODE -> LFD
    data_in = 2'd0;
    repeat (4) tick();                     // LFD -> LOAD_DATA, 3 more payload
    pkt_valid = 1'b0;
    repeat (3) tick();                     // LOAD_PARITY, CHECK, DECODE

    // Busy port: port 2 not empty for 6 cycles
    tag = "wait_empty";
    quiet();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    tick();
    repeat (5) tick();
    fifo_empty_2 = 1'b1;
    tick();                                // -> LFD
    pkt_valid = 1'b0;
    repeat (4) tick();

    // Full stall, resume with low_packet_valid=0 then =1
    tag = "full_stall";
    quiet();
    pkt_valid = 1'b1; data_in = 2'd1;
    repeat (3) tick();                     // LFD, LOAD_DATA, LOAD_DATA
    fifo_full = 1'b1;
    repeat (3) tick();                     // FULL x3
    fifo_full = 1'b0;
    tick();                                // LAF
    tick();                                // LOAD_DATA
    fifo_full = 1'b1; pkt_valid = 1'b0;    // full and pkt_valid fall together
    repeat (2) tick();
    fifo_full = 1'b0;
    tick();                                // LAF
    low_packet_valid = 1'b1;
    repeat (4) tick();                     // LOAD_PARITY, CHECK, DECODE

    // Abort: port 0 stalled; soft_reset_1 ignored, soft_reset_0 aborts
    tag = "abort";
    quiet();
    pkt_valid = 1'b1; data_in = 2'd0;
    repeat (2) tick();
    fifo_full = 1'b1;
    repeat (2) tick();
    soft_reset_1 = 1'b1;
    tick();
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    tick();                                // -> DECODE despite fifo_full
    soft_reset_0 = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
    soft_reset_2 = 1'b1;                   // ignored in DECODE
    tick();

    // Invalid address
    tag = "invalid_addr";
    quiet();
    pkt_valid = 1'b1; data_in = 2'd3;
    repeat (5) tick();

    // Reset mid-packet
    tag = "reset_mid";
    quiet();
    pkt_valid = 1'b1; data_in = 2'd2;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; pkt_valid = 1'b0;
    tick();

    // Randomized traffic
    tag = "random";
    for (int i = 0; i < 4000; i++) begin
      rand_inputs(1'b1);
      tick();
    end

    quiet();
    tick();
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
